// File: rtl/crossbar_nxn_reg.sv
// -----------------------------------------------------------------------------
// crossbar_nxn_reg
//
// Purpose:
//   N_PORTS x N_PORTS valid/ready crossbar. Each input names one output through
//   in_dest. Each output owns a one-word register holding data, source index and
//   valid. A free output, meaning empty or being drained this cycle, grants one
//   of its requesters. The granted word appears on the output one cycle later.
//   Outputs arbitrate independently, so a full permutation moves N_PORTS words
//   per cycle.
//
// Configuration:
//   CROSSBAR_RR_ARB_EN - when defined, each output runs a round-robin arbiter
//                        with its own pointer. When undefined, each output
//                        uses fixed priority (lowest input index wins) and
//                        holds no pointer state.
//
// Parameters:
//   N_PORTS - number of inputs and outputs (2, 4 or 8)
//   WIDTH   - data bits per port
//   DW      - index width, $clog2(N_PORTS) (derived)
//
// Ports:
//   clk        - clock; all state changes on its rising edge
//   rst        - asynchronous active-high reset
//   in_data    - input i word at [i*WIDTH +: WIDTH]
//   in_dest    - output index requested by input i, at [i*DW +: DW]
//   in_valid   - input i offers a word
//   in_ready   - input i's word is accepted this cycle (combinational)
//   out_data   - registered word of output j
//   out_src    - index of the input that supplied out_data j
//   out_valid  - output j holds a word
//   out_ready  - sink of output j accepts the word
// -----------------------------------------------------------------------------
module crossbar_nxn_reg #(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 4,
    localparam int DW     = $clog2(N_PORTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS*WIDTH-1:0] in_data,
    input  logic [N_PORTS*DW-1:0]    in_dest,
    input  logic [N_PORTS-1:0]       in_valid,
    output logic [N_PORTS-1:0]       in_ready,
    output logic [N_PORTS*WIDTH-1:0] out_data,
    output logic [N_PORTS*DW-1:0]    out_src,
    output logic [N_PORTS-1:0]       out_valid,
    input  logic [N_PORTS-1:0]       out_ready
);

    // Bit [j*N_PORTS + i] is set when output j grants input i this cycle.
    logic [N_PORTS*N_PORTS-1:0] gnt_flat;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_out
            logic [N_PORTS-1:0] req;
            logic [N_PORTS-1:0] gnt;
            logic [DW-1:0]      sel;
            logic               hit;
            logic               free;
            logic               load;
            logic [WIDTH-1:0]   data_q, data_d;
            logic [DW-1:0]      src_q, src_d;
            logic               valid_q, valid_d;

            always_comb begin
                req = '0;
                for (int i = 0; i < N_PORTS; i++) begin
                    req[i] = in_valid[i] && (in_dest[i*DW +: DW] == DW'(gi));
                end
            end

`ifdef CROSSBAR_RR_ARB_EN
            logic [DW-1:0] ptr_q, ptr_d;
            logic [DW-1:0] idx;

            // Scan requesters starting at the pointer. N_PORTS is a power of
            // two, so DW-bit wrap-around gives the modulo for free.
            always_comb begin
                sel = '0;
                hit = 1'b0;
                idx = '0;
                for (int k = 0; k < N_PORTS; k++) begin
                    idx = ptr_q + DW'(k);
                    if (!hit && req[idx]) begin
                        hit = 1'b1;
                        sel = idx;
                    end
                end
            end

            // The pointer moves past the winner only when a word is loaded.
            assign ptr_d = load ? (sel + DW'(1)) : ptr_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
`else
            // Fixed priority: the descending scan leaves the lowest index in sel.
            always_comb begin
                sel = '0;
                hit = 1'b0;
                for (int i = N_PORTS - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        hit = 1'b1;
                        sel = DW'(i);
                    end
                end
            end
`endif

            // The register is free when empty or when its word leaves this edge.
            // That lets drain and load happen together at one word per cycle.
            assign free = !valid_q || out_ready[gi];
            assign load = free && hit;

            always_comb begin
                gnt = '0;
                if (load) begin
                    gnt[sel] = 1'b1;
                end
            end

            assign gnt_flat[gi*N_PORTS +: N_PORTS] = gnt;

            always_comb begin
                data_d  = data_q;
                src_d   = src_q;
                valid_d = valid_q;
                if (load) begin
                    for (int i = 0; i < N_PORTS; i++) begin
                        if (gnt[i]) begin
                            data_d = in_data[i*WIDTH +: WIDTH];
                        end
                    end
                    src_d   = sel;
                    valid_d = 1'b1;
                end else if (out_ready[gi]) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    src_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    src_q   <= src_d;
                    valid_q <= valid_d;
                end
            end

            assign out_data[gi*WIDTH +: WIDTH] = data_q;
            assign out_src[gi*DW +: DW]        = src_q;
            assign out_valid[gi]               = valid_q;
        end
    endgenerate

    // Each input requests one output, so OR-ing that input's column across
    // all outputs gives its ready. Ready is forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            for (int j = 0; j < N_PORTS; j++) begin
                in_ready[i] = in_ready[i] | gnt_flat[j*N_PORTS + i];
            end
        end
        if (rst) begin
            in_ready = '0;
        end
    end

endmodule

// File: tb/tb_crossbar_nxn_reg.sv
// -----------------------------------------------------------------------------
// tb_crossbar_nxn_reg
//
// Purpose:
//   Self-checking bench for crossbar_nxn_reg with N_PORTS=4 and WIDTH=4.
//   Directed cases cover identity, swap, contention, backpressure, reset in the
//   middle of a stream and idle. A randomized phase follows. Each cycle is
//   compared against a behavioural model of the per-output registers and the
//   arbitration rules. The bench follows whichever arbitration mode
//   CROSSBAR_RR_ARB_EN selects.
// -----------------------------------------------------------------------------
module tb_crossbar_nxn_reg;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int DW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [N*DW-1:0]  in_dest;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [N*W-1:0]   out_data;
    logic [N*DW-1:0]  out_src;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;

    crossbar_nxn_reg #(.N_PORTS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: one word slot per output plus an arbitration pointer.
    int         m_valid [N];
    int         m_data  [N];
    int         m_src   [N];
    int         m_ptr   [N];
    int         m_win   [N];
    logic [N-1:0] m_rdy;

    function automatic int dest_of(input int i);
        return int'(in_dest[i*DW +: DW]);
    endfunction

    function automatic int data_of(input int i);
        return int'(in_data[i*W +: W]);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_valid[j] = 0; m_data[j] = 0; m_src[j] = 0; m_ptr[j] = 0; m_win[j] = -1;
        end
    endtask

    // Winner per output: among inputs requesting it, lowest rank wins.
    // Rank is the input index (fixed) or its distance from the pointer (RR).
    task automatic model_eval();
        int best, best_rank, rank;
        for (int j = 0; j < N; j++) begin
            m_win[j] = -1;
            if (m_valid[j] == 0 || out_ready[j]) begin
                best = -1;
                best_rank = N;
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && dest_of(i) == j) begin
`ifdef CROSSBAR_RR_ARB_EN
                        rank = (i - m_ptr[j] + N) % N;
`else
                        rank = i;
`endif
                        if (rank < best_rank) begin
                            best_rank = rank;
                            best = i;
                        end
                    end
                end
                m_win[j] = best;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_rdy[i] = !rst && in_valid[i] && (m_win[dest_of(i)] == i);
        end
    endtask

    task automatic model_update();
        for (int j = 0; j < N; j++) begin
            if (m_win[j] >= 0) begin
                m_valid[j] = 1;
                m_data[j]  = data_of(m_win[j]);
                m_src[j]   = m_win[j];
`ifdef CROSSBAR_RR_ARB_EN
                m_ptr[j]   = (m_win[j] + 1) % N;
`endif
            end else if (out_ready[j]) begin
                m_valid[j] = 0;
            end
        end
    endtask

    // Inputs are driven after a falling edge. This task checks the DUT against
    // the model, takes the rising edge, then returns at the next falling edge.
    task automatic cycle();
        #1;
        model_eval();
        chk("in_ready", in_ready, m_rdy);
        for (int j = 0; j < N; j++) begin
            chk("out_valid", out_valid[j], m_valid[j] != 0);
            if (m_valid[j] != 0) begin
                chk("out_data", out_data[j*W +: W], m_data[j]);
                chk("out_src", out_src[j*DW +: DW], m_src[j]);
            end
        end
        $display("cyc=%0d in_valid=%b in_dest=%h in_ready=%b out_ready=%b out_valid=%b out_data=%h out_src=%h",
                 cyc, in_valid, in_dest, in_ready, out_ready, out_valid, out_data, out_src);
        cyc++;
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input int i, input logic [W-1:0] d, input logic [DW-1:0] dst, input logic v);
        in_data[i*W +: W]   = d;
        in_dest[i*DW +: DW] = dst;
        in_valid[i]         = v;
    endtask

    task automatic clear_in();
        for (int i = 0; i < N; i++) set_in(i, '0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_seq [4];
    logic [N-1:0] acc;

    initial begin
`ifdef CROSSBAR_RR_ARB_EN
        exp_seq = '{0, 1, 2, 0};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        rst = 1'b1;
        out_ready = '0;
        clear_in();
        model_reset();
        // Offer words during reset: ready must still stay low.
        for (int i = 0; i < N; i++) set_in(i, 4'(i + 1), 2'(i), 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_src", out_src, 0);
        chk("reset_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_in();

        // Identity permutation: four words per cycle.
        out_ready = 4'hF;
        for (int i = 0; i < N; i++) set_in(i, 4'(4'hA + i), 2'(i), 1'b1);
        #1 chk("id_in_ready", in_ready, 4'hF);
        cycle();
        cycle();
        chk("id_out_data", out_data, 16'hDCBA);
        chk("id_out_src", out_src, 8'hE4);
        chk("id_out_valid", out_valid, 4'hF);

        // Reset in mid-stream: outputs drop immediately and stay empty.
        pulse_reset();
        clear_in();
        cycle();
        chk("rst_no_old_data", out_valid, 0);

        // Swap between inputs 0 and 1.
        set_in(0, 4'h3, 2'd1, 1'b1);
        set_in(1, 4'hC, 2'd0, 1'b1);
        cycle();
        chk("swap_data0", out_data[3:0], 4'hC);
        chk("swap_src0", out_src[1:0], 1);
        chk("swap_data1", out_data[7:4], 4'h3);
        chk("swap_src1", out_src[3:2], 0);
        clear_in();
        cycle();

        // Contention: inputs 0..2 all want output 3 and keep offering.
        pulse_reset();
        set_in(0, 4'h1, 2'd3, 1'b1);
        set_in(1, 4'h2, 2'd3, 1'b1);
        set_in(2, 4'h3, 2'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1 chk("cont_in_ready", in_ready, 4'b0001 << exp_seq[k]);
            cycle();
            chk("cont_src3", out_src[7:6], exp_seq[k]);
            chk("cont_data3", out_data[15:12], exp_seq[k] + 1);
        end
        // Move the pointer again, then reset; arbitration must restart at input 0.
        cycle();
        pulse_reset();
        cycle();
        chk("restart_src3", out_src[7:6], 0);
        clear_in();
        cycle();

        // Backpressure on output 2.
        out_ready = 4'b1011;
        set_in(0, 4'h5, 2'd2, 1'b1);
        cycle();
        chk("bp_load_valid", out_valid[2], 1);
        chk("bp_load_data", out_data[11:8], 4'h5);
        set_in(0, 4'h0, 2'd0, 1'b0);
        set_in(1, 4'h9, 2'd2, 1'b1);
        #1 chk("bp_blocked_ready", in_ready[1], 0);
        cycle();
        chk("bp_hold_data", out_data[11:8], 4'h5);
        chk("bp_hold_src", out_src[5:4], 0);
        cycle();
        chk("bp_hold_data2", out_data[11:8], 4'h5);
        out_ready = 4'hF;
        #1 chk("bp_release_ready", in_ready[1], 1);
        cycle();
        chk("bp_reload_data", out_data[11:8], 4'h9);
        chk("bp_reload_src", out_src[5:4], 1);

        // Idle: no offers, outputs drain.
        clear_in();
        #1 chk("idle_in_ready", in_ready, 0);
        cycle();
        chk("idle_drained", out_valid, 0);

        // Random traffic. Each source holds its word until the model says it
        // was accepted.
        acc = '0;
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < N; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 9) < 7)
                        set_in(i, 4'($urandom), 2'($urandom), 1'b1);
                    else
                        set_in(i, 4'h0, 2'd0, 1'b0);
                end
            end
            cycle();
            acc = m_rdy;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
